// File: rtl/mop_issue_queue.sv
// rtl/mop_issue_queue.sv - in-order micro-op issue queue between decoder and one execution pipeline
//
// Buffers decoded micro-ops in a DEPTH-entry circular FIFO and issues at most one per
// cycle to the pipeline as a single-cycle pipe_in_ready pulse with pipe_in_mop.
// Optional build macro: MOP_ISSUE_BYPASS_EN (empty queue forwards dec_mop straight
// into the issue register, 1-cycle push-to-issue latency instead of 2).
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous active-high reset
//   dec_valid      in   decoder presents a micro-op
//   dec_mop        in   [MOP_W-1:0] micro-op from decoder
//   dec_full       out  queue full, decoder must hold (dec_valid while high is dropped)
//   flush          in   discard all queued micro-ops
//   pipe_busy      in   pipeline cannot accept this cycle
//   pipe_in_ready  out  one-cycle issue pulse
//   pipe_in_mop    out  [MOP_W-1:0] issued micro-op (held between issues)
//   occupancy      out  [$clog2(DEPTH+1)-1:0] entries queued (issue register excluded)
//   issue_count    out  [31:0] micro-ops issued since reset, wrapping

module mop_issue_queue #(
  parameter int DEPTH = 4,
  parameter int MOP_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dec_valid,
  input  logic [MOP_W-1:0]           dec_mop,
  output logic                       dec_full,
  input  logic                       flush,
  input  logic                       pipe_busy,
  output logic                       pipe_in_ready,
  output logic [MOP_W-1:0]           pipe_in_mop,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                issue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [MOP_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_issue_vld;
  logic [MOP_W-1:0] r_issue_mop;
  logic [31:0]      r_issue_count;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_byp;

  // Full comes from the registered count only: a pop in the same cycle does not
  // free a slot for a push until the next edge.
  assign w_full = (r_count == CNT_FULL);

`ifdef MOP_ISSUE_BYPASS_EN
  assign w_byp = (r_count == '0) && dec_valid && !pipe_busy && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed micro-op goes straight to the issue register and never enters the queue.
  assign w_push = dec_valid && !w_full && !flush && !w_byp;
  assign w_pop  = (r_count != '0) && !pipe_busy && !flush;

  // Storage carries no reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_tail] <= dec_mop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_issue_vld   <= 1'b0;
      r_issue_mop   <= '0;
      r_issue_count <= '0;
    end else if (flush) begin
      // issue_count and the last issued micro-op are intentionally kept.
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_issue_vld <= 1'b0;
    end else begin
      r_issue_vld <= w_pop || w_byp;
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_issue_mop <= r_mem[r_head];
        r_head      <= r_head + PTR_ONE;
      end else if (w_byp) begin
        r_issue_mop <= dec_mop;
      end
      if (w_pop || w_byp) begin
        r_issue_count <= r_issue_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dec_full      = w_full;
  assign pipe_in_ready = r_issue_vld;
  assign pipe_in_mop   = r_issue_mop;
  assign occupancy     = r_count;
  assign issue_count   = r_issue_count;

endmodule

// File: tb/tb_mop_issue_queue.sv
// tb/tb_mop_issue_queue.sv - directed self-checking bench for mop_issue_queue (base build)

module tb_mop_issue_queue;

  localparam int DEPTH = 4;
  localparam int MOP_W = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid;
  logic [MOP_W-1:0] dec_mop;
  logic             dec_full;
  logic             flush;
  logic             pipe_busy;
  logic             pipe_in_ready;
  logic [MOP_W-1:0] pipe_in_mop;
  logic [CW-1:0]    occupancy;
  logic [31:0]      issue_count;

  int n_cmp = 0;
  int n_err = 0;

  mop_issue_queue #(.DEPTH(DEPTH), .MOP_W(MOP_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_mop       (dec_mop),
    .dec_full      (dec_full),
    .flush         (flush),
    .pipe_busy     (pipe_busy),
    .pipe_in_ready (pipe_in_ready),
    .pipe_in_mop   (pipe_in_mop),
    .occupancy     (occupancy),
    .issue_count   (issue_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dec_valid = 1'b0; dec_mop = '0; flush = 1'b0; pipe_busy = 1'b0;
    step(); step();
    n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b exp=0", pipe_in_ready); end
    n_cmp++; if (dec_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", dec_full); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    n_cmp++; if (pipe_in_mop !== 16'h0) begin n_err++; $display("FAIL reset_mop got=%h exp=0", pipe_in_mop); end
    n_cmp++; if (issue_count !== 32'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", issue_count); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [MOP_W-1:0] exp_mop [3];
    exp_mop[0] = 16'hA00A; exp_mop[1] = 16'hB00B; exp_mop[2] = 16'hC00C;
    dec_valid = 1'b1; dec_mop = exp_mop[0];
    step();
    // Accepted at this edge, not issued yet: base latency is two cycles.
    n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_lat_rdy got=%b exp=0", pipe_in_ready); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL b2b_occ1 got=%0d exp=1", occupancy); end
    dec_mop = exp_mop[1];
    step();
    n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_in_mop !== exp_mop[0]) begin n_err++; $display("FAIL b2b_issue0 rdy=%b mop=%h exp rdy=1 mop=%h", pipe_in_ready, pipe_in_mop, exp_mop[0]); end
    dec_mop = exp_mop[2];
    step();
    n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_in_mop !== exp_mop[1]) begin n_err++; $display("FAIL b2b_issue1 rdy=%b mop=%h exp rdy=1 mop=%h", pipe_in_ready, pipe_in_mop, exp_mop[1]); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL b2b_occ_mid got=%0d exp=1", occupancy); end
    dec_valid = 1'b0;
    step();
    n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_in_mop !== exp_mop[2]) begin n_err++; $display("FAIL b2b_issue2 rdy=%b mop=%h exp rdy=1 mop=%h", pipe_in_ready, pipe_in_mop, exp_mop[2]); end
    step();
    n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_idle_rdy got=%b exp=0", pipe_in_ready); end
    n_cmp++; if (issue_count !== 32'd3) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=3", issue_count); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL b2b_occ_end got=%0d exp=0", occupancy); end
  endtask

  task automatic test_full_drop();
    pipe_busy = 1'b1; dec_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_mop = 16'h1000 + 16'(i);
      step();
      n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL full_busy_rdy%0d got=%b exp=0", i, pipe_in_ready); end
    end
    n_cmp++; if (dec_full !== 1'b1) begin n_err++; $display("FAIL full_flag got=%b exp=1", dec_full); end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    dec_mop = 16'hDEAD;
    step();
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_drop_occ got=%0d exp=4", occupancy); end
    dec_valid = 1'b0; pipe_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_in_mop !== 16'h1000 + 16'(i)) begin n_err++; $display("FAIL full_drain%0d rdy=%b mop=%h exp rdy=1 mop=%h", i, pipe_in_ready, pipe_in_mop, 16'h1000 + 16'(i)); end
      n_cmp++; if (occupancy !== 3'(3 - i)) begin n_err++; $display("FAIL full_drain_occ%0d got=%0d exp=%0d", i, occupancy, 3 - i); end
    end
    step();
    n_cmp++; if (pipe_in_ready !== 1'b0 || issue_count !== 32'd7) begin n_err++; $display("FAIL full_end rdy=%b cnt=%0d exp rdy=0 cnt=7", pipe_in_ready, issue_count); end
  endtask

  task automatic test_full_no_credit();
    pipe_busy = 1'b1; dec_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_mop = 16'h2000 + 16'(i);
      step();
    end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL nc_occ4 got=%0d exp=4", occupancy); end
    pipe_busy = 1'b0; dec_mop = 16'hEEEE;
    step();
    // Full at the edge: pop happens, push is refused.
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL nc_occ3a got=%0d exp=3", occupancy); end
    n_cmp++; if (pipe_in_mop !== 16'h2000) begin n_err++; $display("FAIL nc_issue0 got=%h exp=2000", pipe_in_mop); end
    step();
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL nc_occ3b got=%0d exp=3", occupancy); end
    n_cmp++; if (pipe_in_mop !== 16'h2001) begin n_err++; $display("FAIL nc_issue1 got=%h exp=2001", pipe_in_mop); end
    dec_valid = 1'b0;
    step();
    n_cmp++; if (pipe_in_mop !== 16'h2002) begin n_err++; $display("FAIL nc_issue2 got=%h exp=2002", pipe_in_mop); end
    step();
    n_cmp++; if (pipe_in_mop !== 16'h2003) begin n_err++; $display("FAIL nc_issue3 got=%h exp=2003", pipe_in_mop); end
    step();
    n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_in_mop !== 16'hEEEE) begin n_err++; $display("FAIL nc_issueE rdy=%b mop=%h exp rdy=1 mop=eeee", pipe_in_ready, pipe_in_mop); end
    step();
    n_cmp++; if (issue_count !== 32'd12 || occupancy !== 3'd0) begin n_err++; $display("FAIL nc_end cnt=%0d occ=%0d exp cnt=12 occ=0", issue_count, occupancy); end
  endtask

  task automatic test_wrap();
    pipe_busy = 1'b1; dec_valid = 1'b1;
    dec_mop = 16'h3000; step();
    dec_mop = 16'h3001; step();
    pipe_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dec_mop = 16'h3002 + 16'(i);
      step();
      n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL wrap_occ%0d got=%0d exp=2", i, occupancy); end
      n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_in_mop !== 16'h3000 + 16'(i)) begin n_err++; $display("FAIL wrap_issue%0d rdy=%b mop=%h exp rdy=1 mop=%h", i, pipe_in_ready, pipe_in_mop, 16'h3000 + 16'(i)); end
    end
    dec_valid = 1'b0;
    step();
    n_cmp++; if (pipe_in_mop !== 16'h3006) begin n_err++; $display("FAIL wrap_tail0 got=%h exp=3006", pipe_in_mop); end
    step();
    n_cmp++; if (pipe_in_mop !== 16'h3007) begin n_err++; $display("FAIL wrap_tail1 got=%h exp=3007", pipe_in_mop); end
    step();
    n_cmp++; if (issue_count !== 32'd20) begin n_err++; $display("FAIL wrap_cnt got=%0d exp=20", issue_count); end
  endtask

  task automatic test_flush();
    pipe_busy = 1'b1; dec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec_mop = 16'h4000 + 16'(i);
      step();
    end
    n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
    flush = 1'b1; pipe_busy = 1'b0; dec_mop = 16'h4003;
    step();
    n_cmp++; if (occupancy !== 3'd0 || pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_clear occ=%0d rdy=%b exp occ=0 rdy=0", occupancy, pipe_in_ready); end
    n_cmp++; if (issue_count !== 32'd20) begin n_err++; $display("FAIL flush_cnt got=%0d exp=20", issue_count); end
    flush = 1'b0; dec_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (pipe_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ghost%0d rdy=%b mop=%h exp rdy=0", i, pipe_in_ready, pipe_in_mop); end
    end
    n_cmp++; if (pipe_in_mop !== 16'h3007) begin n_err++; $display("FAIL flush_hold_mop got=%h exp=3007", pipe_in_mop); end
    n_cmp++; if (issue_count !== 32'd20) begin n_err++; $display("FAIL flush_cnt_after got=%0d exp=20", issue_count); end
  endtask

  task automatic test_reset_mid();
    pipe_busy = 1'b1; dec_valid = 1'b1;
    dec_mop = 16'h5000; step();
    dec_mop = 16'h5001; step();
    n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL rmid_pre_occ got=%0d exp=2", occupancy); end
    reset = 1'b1; pipe_busy = 1'b0;
    step();
    n_cmp++; if (occupancy !== 3'd0 || pipe_in_ready !== 1'b0 || dec_full !== 1'b0) begin n_err++; $display("FAIL rmid_ctl occ=%0d rdy=%b full=%b exp 0/0/0", occupancy, pipe_in_ready, dec_full); end
    n_cmp++; if (pipe_in_mop !== 16'h0 || issue_count !== 32'd0) begin n_err++; $display("FAIL rmid_data mop=%h cnt=%0d exp 0/0", pipe_in_mop, issue_count); end
    reset = 1'b0; dec_mop = 16'h6006;
    step();
    n_cmp++; if (pipe_in_ready !== 1'b0 || occupancy !== 3'd1) begin n_err++; $display("FAIL rmid_push rdy=%b occ=%0d exp rdy=0 occ=1", pipe_in_ready, occupancy); end
    dec_valid = 1'b0;
    step();
    n_cmp++; if (pipe_in_ready !== 1'b1 || pipe_in_mop !== 16'h6006) begin n_err++; $display("FAIL rmid_issue rdy=%b mop=%h exp rdy=1 mop=6006", pipe_in_ready, pipe_in_mop); end
    step();
    n_cmp++; if (pipe_in_ready !== 1'b0 || issue_count !== 32'd1) begin n_err++; $display("FAIL rmid_end rdy=%b cnt=%0d exp rdy=0 cnt=1", pipe_in_ready, issue_count); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_drop();
    test_full_no_credit();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
